// File: rtl/send_recv_incr_pipe.sv
// Purpose: en/rdy increment stage; receive queue -> output register adding cfg_incr (wrap or clamp).
// Latency: 1 cycle recv->send minimum (enqueue edge N, load edge N+1), 1 msg/cycle sustained.
// Backpressure: send_rdy low holds the output register; the queue fills and recv_rdy drops when full.
module send_recv_incr_pipe #(
  parameter int p_nbits       = 32,
  parameter int p_num_entries = 2,
  parameter int p_saturate    = 0,
  parameter int p_count_nbits = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [p_nbits-1:0]                     cfg_incr,
  output logic                                   recv_rdy,
  input  logic                                   recv_en,
  input  logic [p_nbits-1:0]                     recv_msg,
  input  logic                                   send_rdy,
  output logic                                   send_en,
  output logic [p_nbits-1:0]                     send_msg,
  output logic [$clog2(p_num_entries+1)-1:0]     num_free_entries,
  output logic [p_count_nbits-1:0]               msg_count,
  output logic                                   sat_pulse
);

  localparam int c_cnt_w = $clog2(p_num_entries + 1);
  localparam int c_ptr_w = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(p_num_entries - 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(p_num_entries);

  logic [p_nbits-1:0] mem [p_num_entries];
  logic [c_ptr_w-1:0] wr_ptr;
  logic [c_ptr_w-1:0] rd_ptr;
  logic [c_cnt_w-1:0] count;
  logic               out_val;
  logic [p_nbits-1:0] out_msg;

  logic               enq;
  logic               deq;
  logic [p_nbits:0]   sum;
  logic               ovf;
  logic [p_nbits-1:0] result;

  // Full queue refuses input even if the head leaves this cycle (no bypass).
  assign recv_rdy         = (count != c_depth);
  assign enq              = recv_en && recv_rdy;
  assign send_en          = out_val && send_rdy;
  assign send_msg         = send_en ? out_msg : '0;
  // Head moves into the output register when that register is empty or draining now.
  assign deq              = (count != '0) && (!out_val || send_en);
  assign num_free_entries = c_depth - count;

  // One extra bit catches the carry so saturation can detect overflow.
  assign sum    = {1'b0, mem[rd_ptr]} + {1'b0, cfg_incr};
  assign ovf    = sum[p_nbits];
  assign result = ((p_saturate != 0) && ovf) ? '1 : sum[p_nbits-1:0];

  // Queue storage: payload only, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= recv_msg;
  end

  // Queue pointers and occupancy; reset discards everything held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == c_last) ? '0 : wr_ptr + 1'b1;
      if (deq) rd_ptr <= (rd_ptr == c_last) ? '0 : rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output register: load incremented head, or go empty after the last send.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val <= 1'b0;
      out_msg <= '0;
    end else if (deq) begin
      out_val <= 1'b1;
      out_msg <= result;
    end else if (send_en) begin
      out_val <= 1'b0;
    end
  end

  // Clamp indication, registered so it appears the cycle after the load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_pulse <= 1'b0;
    else        sat_pulse <= deq && ovf && (p_saturate != 0);
  end

  // Count of delivered messages, free-running wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       msg_count <= '0;
    else if (send_en) msg_count <= msg_count + 1'b1;
  end

endmodule
